// File: rtl/mult_arbiter.sv
// Round-robin front end that lets several requesters share one pipelined multiplier.
// Issue-order tags are queued so each product is strobed back to the requester that issued it.
module mult_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [63:0]           resp_result,
  output logic                  m_valid_in,
  output logic [31:0]           m_a,
  output logic [31:0]           m_b,
  input  logic                  m_valid_out,
  input  logic [63:0]           m_result,
  output logic [4:0]            inflight,
  output logic                  err_orphan
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int FW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;
  logic             pop;
  logic [PTR_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [FW-1:0]    wr_ptr;
  logic [FW-1:0]    rd_ptr;

  function automatic logic [FW-1:0] ptr_next(input logic [FW-1:0] p);
    return (p == FW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready is masked by rst_n so nothing is offered while the block is held in reset.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    if (rst_n && (inflight < 5'(MAX_INFLIGHT))) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
          grant_found = 1'b1;
          grant_idx   = PTR_W'((int'(rr_ptr) + k) % N_REQ);
        end
      end
      req_ready[grant_idx] = grant_found;
    end
  end

  assign accept = grant_found;
  assign pop    = m_valid_out && (inflight != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      m_valid_in  <= 1'b0;
      m_a         <= '0;
      m_b         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      err_orphan  <= 1'b0;
    end else begin
      m_valid_in <= accept;
      if (accept) begin
        m_a    <= req_a[int'(grant_idx)*32 +: 32];
        m_b    <= req_b[int'(grant_idx)*32 +: 32];
        rr_ptr <= PTR_W'((int'(grant_idx) + 1) % N_REQ);
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr      <= ptr_next(rd_ptr);
        resp_result <= m_result;
      end
      if (accept && !pop) begin
        inflight <= inflight + 5'd1;
      end else if (pop && !accept) begin
        inflight <= inflight - 5'd1;
      end
      resp_valid <= pop ? (N_REQ'(1) << tag_mem[rd_ptr]) : '0;
      // A return with nothing outstanding means the multiplier and this tracker disagree.
      if (m_valid_out && (inflight == 5'd0)) begin
        err_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural L-stage signed multiplier attached.
module tb_mult_arbiter;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid, req_ready, resp_valid;
  logic [63:0] req_a, req_b, resp_result;
  logic        m_valid_in, m_valid_out;
  logic [31:0] m_a, m_b;
  logic [63:0] m_result;
  logic [4:0]  inflight;
  logic        err_orphan;
  logic        force_vout;
  logic        pv [L];
  logic [63:0] pr [L];

  logic [1:0]  req_valid2, req_ready2, resp_valid2;
  logic [63:0] req_a2, req_b2, resp_result2, m2_result;
  logic        m_valid_in2, m2_valid_out, err_orphan2;
  logic [31:0] m_a2, m_b2;
  logic [4:0]  inflight2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(2), .MAX_INFLIGHT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_result(resp_result),
    .m_valid_in(m_valid_in), .m_a(m_a), .m_b(m_b), .m_valid_out(m_valid_out),
    .m_result(m_result), .inflight(inflight), .err_orphan(err_orphan));

  mult_arbiter #(.N_REQ(2), .MAX_INFLIGHT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .resp_valid(resp_valid2), .resp_result(resp_result2),
    .m_valid_in(m_valid_in2), .m_a(m_a2), .m_b(m_b2), .m_valid_out(m2_valid_out),
    .m_result(m2_result), .inflight(inflight2), .err_orphan(err_orphan2));

  // Multiplier model: signed 32x32 product, L register stages, cleared by the shared reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pr[i] <= '0;
      end
    end else begin
      pv[0] <= m_valid_in;
      pr[0] <= $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end

  assign m_valid_out = pv[L-1] | force_vout;
  assign m_result    = pr[L-1];

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  exp_valid;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    check({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, ".resp_result"}, resp_result, 64'd0);
    check({tag, ".m_valid_in"}, 64'(m_valid_in), 64'd0);
    check({tag, ".m_a"}, 64'(m_a), 64'd0);
    check({tag, ".m_b"}, 64'(m_b), 64'd0);
    check({tag, ".inflight"}, 64'(inflight), 64'd0);
    check({tag, ".err_orphan"}, 64'(err_orphan), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated request; the other requester carries junk operands that must be ignored.
  task automatic run_single(input vec_t v, input string name);
    int cyc;
    @(negedge clk);
    req_a = {2{32'hDEAD_BEEF}};
    req_b = {2{32'hDEAD_BEEF}};
    req_a[v.r*32 +: 32] = v.a;
    req_b[v.r*32 +: 32] = v.b;
    req_valid = 2'b01 << v.r;
    #1 check({name, ".req_ready"}, 64'(req_ready), 64'(2'b01 << v.r));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check({name, ".m_valid_in"}, 64'(m_valid_in), 64'd1);
    check({name, ".m_a"}, 64'(m_a), 64'(v.a));
    check({name, ".m_b"}, 64'(m_b), 64'(v.b));
    cyc = 1;
    while (resp_valid === 2'b00 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, ".latency"}, 64'(cyc), 64'(L + 2));
    check({name, ".resp_valid"}, 64'(resp_valid), 64'(v.exp_valid));
    check({name, ".resp_result"}, resp_result, v.exp_res);
  endtask

  initial begin
    logic [1:0]  rr_exp_v [4];
    logic [63:0] rr_exp_r [4];
    int got;
    int stray;

    req_valid = '0; req_a = '0; req_b = '0; force_vout = 1'b0;
    req_valid2 = '0; req_a2 = {32'd2, 32'd1}; req_b2 = {32'd4, 32'd3};
    m2_valid_out = 1'b0; m2_result = '0;

    vecs[0] = '{0, 32'd7,          32'hFFFF_FFFD, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 2'b10, 64'h0000_0000_8000_0000};
    vecs[2] = '{0, 32'd0,          32'h1234_5678, 2'b01, 64'h0};
    vecs[3] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b10, 64'h1};
    vecs[4] = '{0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 2'b01, 64'h3FFF_FFFF_0000_0001};
    vecs[5] = '{1, 32'h8000_0000,  32'h8000_0000, 2'b10, 64'h4000_0000_0000_0000};
    vecs[6] = '{0, 32'h1234_5678,  32'd2,         2'b01, 64'h0000_0000_2468_ACF0};
    vecs[7] = '{1, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 2'b10, 64'h1E};

    // Reset state, with both requesters asserting valid while held in reset.
    @(negedge clk);
    req_valid = 2'b11;
    #1 check_zero("reset");
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i], $sformatf("vec%0d", i));
    end
    #1 check("vec.inflight_idle", 64'(inflight), 64'd0);

    // Both requesters valid from reset: grants and responses alternate 0,1,0,1.
    do_reset();
    req_a = {32'd5, 32'd2};
    req_b = {32'd7, 32'd3};
    req_valid = 2'b11;
    rr_exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
    rr_exp_r = '{64'd6, 64'd35, 64'd6, 64'd35};
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr.grant%0d", i), 64'(req_ready), 64'(rr_exp_v[i]));
      if (i == 3) check("rr.inflight", 64'(inflight), 64'd3);
      @(negedge clk);
    end
    req_valid = 2'b00;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      #1;
      if (resp_valid !== 2'b00) begin
        check($sformatf("rr.resp_valid%0d", got), 64'(resp_valid), 64'(rr_exp_v[got]));
        check($sformatf("rr.resp_result%0d", got), resp_result, rr_exp_r[got]);
        got++;
      end
      @(negedge clk);
    end
    check("rr.resp_count", 64'(got), 64'd4);

    // MAX_INFLIGHT=2 with the multiplier silent: two accepts, then blocked until a return.
    @(negedge clk);
    req_valid2 = 2'b01;
    #1 check("full.acc1", 64'(req_ready2), 64'(2'b01));
    @(negedge clk);
    #1 check("full.acc2", 64'(req_ready2), 64'(2'b01));
    check("full.inflight1", 64'(inflight2), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("full.blocked%0d", i), 64'(req_ready2), 64'd0);
      check($sformatf("full.inflight2_%0d", i), 64'(inflight2), 64'd2);
    end
    @(negedge clk);
    m2_valid_out = 1'b1;
    m2_result = 64'h0000_CAFE_0000_BEEF;
    #1 check("full.ready_on_return", 64'(req_ready2), 64'd0);
    @(negedge clk);
    m2_valid_out = 1'b0;
    #1 check("full.inflight_after_pop", 64'(inflight2), 64'd1);
    check("full.resp_valid", 64'(resp_valid2), 64'(2'b01));
    check("full.resp_result", resp_result2, 64'h0000_CAFE_0000_BEEF);
    check("full.resume", 64'(req_ready2), 64'(2'b01));
    @(negedge clk);
    #1 check("full.reblocked", 64'(req_ready2), 64'd0);
    check("full.inflight_refull", 64'(inflight2), 64'd2);
    req_valid2 = 2'b00;

    // Return strobe with nothing outstanding.
    @(negedge clk);
    force_vout = 1'b1;
    @(negedge clk);
    force_vout = 1'b0;
    #1 check("orphan.flag", 64'(err_orphan), 64'd1);
    check("orphan.resp_valid", 64'(resp_valid), 64'd0);
    check("orphan.inflight", 64'(inflight), 64'd0);
    repeat (3) @(negedge clk);
    #1 check("orphan.sticky", 64'(err_orphan), 64'd1);

    // Reset with three operations outstanding, then a fresh request completes cleanly.
    @(negedge clk);
    req_a = {32'd1, 32'd3};
    req_b = {32'd1, 32'd4};
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1 check("rstmid.inflight", 64'(inflight), 64'd3);
    check("rstmid.m_valid_in", 64'(m_valid_in), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_zero("rstmid");
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 if (resp_valid !== 2'b00) stray++;
    end
    check("rstmid.stale_resp", 64'(stray), 64'd0);
    run_single('{1, 32'd9, 32'hFFFF_FFFE, 2'b10, 64'hFFFF_FFFF_FFFF_FFEE}, "post_rst");
    check("post_rst.err_orphan", 64'(err_orphan), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, meaning number of requesters (legal 2..4).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8, meaning maximum issued-but-unreturned operations (legal 1..16).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  N_REQ*32  operand A per requester, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b  input  N_REQ*32  operand B, same packing.
REQ-009 SHALL have port resp_valid  output  N_REQ  one-hot result strobe to the owning requester.
REQ-010 SHALL have port resp_result  output  64  product for the strobed requester.
REQ-011 SHALL have port m_valid_in  output  1  issue strobe to pipelined_multiplier valid_in.
REQ-012 SHALL have port m_a  output  32  to pipelined_multiplier a.
REQ-013 SHALL have port m_b  output  32  to pipelined_multiplier b.
REQ-014 SHALL have port m_valid_out  input  1  from pipelined_multiplier valid_out.
REQ-015 SHALL have port m_result  input  64  from pipelined_multiplier result.
REQ-016 SHALL have port inflight  output  5  current outstanding-operation count.
REQ-017 SHALL have port err_orphan  output  1  sticky: result returned with no outstanding tag.

Function
REQ-018 SHALL accept requester i in a cycle (req_valid[i] & req_ready[i]) only when inflight < MAX_INFLIGHT.
REQ-019 SHALL select the grantee round-robin: search starts at rr_ptr, wraps modulo N_REQ, first req_valid wins; req_ready is combinational from req_valid, rr_ptr, inflight.
REQ-020 SHALL set rr_ptr to (grantee+1) mod N_REQ after a grant; rr_ptr unchanged when no grant.
REQ-021 SHALL register the accepted operands: m_valid_in=1, m_a, m_b driven the cycle after acceptance; m_valid_in=0 otherwise, m_a/m_b hold last value.
REQ-022 SHALL pass operands bit-exact (signed interpretation belongs to the multiplier; no extension or truncation).
REQ-023 SHALL push the grantee index into a tag FIFO of depth MAX_INFLIGHT in the acceptance cycle; SHALL pop on m_valid_out.
REQ-024 SHALL increment inflight on acceptance, decrement on m_valid_out with non-empty FIFO, leave unchanged when both occur in the same cycle.
REQ-025 SHALL drive resp_valid = one-hot(popped tag) and resp_result = m_result registered, one cycle after m_valid_out; resp_valid=0 otherwise.
REQ-026 SHALL return results in issue order; total latency acceptance-to-resp_valid = multiplier latency + 2 cycles.
REQ-027 SHALL, on m_valid_out with empty FIFO, set err_orphan, produce no resp_valid, leave inflight at 0.
REQ-028 SHALL sustain one acceptance per cycle while inflight < MAX_INFLIGHT (back-to-back from one or many requesters).
REQ-029 SHALL at inflight == MAX_INFLIGHT hold all req_ready low, even if m_valid_out is high that cycle; acceptance resumes the following cycle.
REQ-030 SHALL ignore req_a/req_b of non-granted requesters; a requester holding req_valid keeps its operands until accepted.

Reset
REQ-031 SHALL on rst_n low asynchronously clear: req_ready=0, resp_valid=0, resp_result=0, m_valid_in=0, m_a=0, m_b=0, inflight=0, err_orphan=0, rr_ptr=0, FIFO empty.
REQ-032 SHALL discard outstanding operations on reset mid-operation; the multiplier shares rst_n (inverted) so no stale results return.
REQ-033 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Verification
REQ-034 SHALL cover: requester 0 alone, a=7, b=-3 -> resp_valid=01, resp_result=-21 (sign-extended to 64 bits) at latency L+2.
REQ-035 SHALL cover: both requesters valid continuously from reset -> grants alternate 0,1,0,1; responses alternate in the same order.
REQ-036 SHALL cover: MAX_INFLIGHT=2, multiplier stalled (no m_valid_out) -> exactly 2 accepts, then req_ready=0 and inflight=2 until a return.
REQ-037 SHALL cover: a=32'h80000000, b=-1 from requester 1 -> resp_valid=10, resp_result=64'h0000_0000_8000_0000.
REQ-038 SHALL cover: m_valid_out forced high with inflight=0 -> err_orphan=1, no resp_valid; cleared only by rst_n.
REQ-039 SHALL cover: rst_n asserted with 3 operations outstanding -> all outputs zero immediately; after release, new request completes with correct tag.
